// File: rtl/capture_line_scheduler_if.sv
// Pixel-stream input and Avalon-MM write-master signals of the capture line scheduler.
interface capture_line_scheduler_if;
  logic        pix_valid;
  logic        pix_sof;
  logic [31:0] pix_data;
  logic [31:0] avm_address;
  logic        avm_write;
  logic [31:0] avm_writedata;
  logic        avm_waitrequest;

  modport master (
    input  pix_valid, pix_sof, pix_data, avm_waitrequest,
    output avm_address, avm_write, avm_writedata
  );
  modport slave (
    output pix_valid, pix_sof, pix_data, avm_waitrequest,
    input  avm_address, avm_write, avm_writedata
  );
endinterface

// File: rtl/capture_line_scheduler.sv
// Buffers a captured pixel stream in a small FIFO and writes it line by line into
// two ping-pong line buffers over Avalon-MM, skipping lines whose buffer is still busy.
module capture_line_scheduler #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start_capture,
  input  logic [15:0] capture_width,
  input  logic [15:0] capture_height,
  input  logic [31:0] buff0,
  input  logic [31:0] buff1,
  input  logic        buff0_busy,
  input  logic        buff1_busy,
  capture_line_scheduler_if.master bus,
  output logic        buff0full,
  output logic        buff1full,
  output logic        frame_done,
  output logic        overflow,
  output logic        busy
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, WAIT_SOF, CHECK_BUF, LINE, DROP, LINE_END} state_t;

  state_t        state_q, state_d;
  logic          start_prev_q;
  logic [15:0]   width_q, width_d, height_q, height_d;
  logic [31:0]   base0_q, base0_d, base1_q, base1_d;
  logic          sel_q, sel_d, drop_q, drop_d, overflow_q, overflow_d;
  logic [15:0]   line_q, line_d, k_q, k_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic [31:0]   mem_q [FIFO_DEPTH];

  logic fifo_empty, fifo_full, wr, accept, abort, start_edge, push_req, push, pop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign abort      = !start_capture;
  assign start_edge = start_capture && !start_prev_q;
  // Outputs derive from registered state so async reset drops the bus write at once.
  assign wr         = (state_q == LINE) && !fifo_empty;
  assign accept     = wr && !bus.avm_waitrequest;

  assign bus.avm_write     = wr;
  assign bus.avm_address   = wr ? ((sel_q ? base1_q : base0_q) + 32'({k_q, 2'b00})) : '0;
  assign bus.avm_writedata = wr ? mem_q[rptr_q] : '0;

  assign buff0full  = (state_q == LINE_END) && start_capture && !drop_q && !sel_q;
  assign buff1full  = (state_q == LINE_END) && start_capture && !drop_q &&  sel_q;
  assign frame_done = (state_q == LINE_END) && start_capture && (line_q + 16'd1 == height_q);
  assign overflow   = overflow_q;
  assign busy       = (state_q != IDLE);

  always_comb begin
    state_d    = state_q;
    width_d    = width_q;
    height_d   = height_q;
    base0_d    = base0_q;
    base1_d    = base1_q;
    sel_d      = sel_q;
    drop_d     = drop_q;
    overflow_d = overflow_q;
    line_d     = line_q;
    k_d        = k_q;
    push_req   = 1'b0;
    pop        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_edge && capture_width != '0 && capture_height != '0) begin
          state_d    = WAIT_SOF;
          width_d    = capture_width;
          height_d   = capture_height;
          base0_d    = buff0;
          base1_d    = buff1;
          sel_d      = 1'b0;
          line_d     = '0;
          overflow_d = 1'b0;
        end
      end
      WAIT_SOF: begin
        push_req = bus.pix_valid && bus.pix_sof;
        if (abort)         state_d = IDLE;
        else if (push_req) state_d = CHECK_BUF;
      end
      CHECK_BUF: begin
        push_req = bus.pix_valid;
        if (abort) state_d = IDLE;
        else begin
          k_d     = '0;
          drop_d  = sel_q ? buff1_busy : buff0_busy;
          state_d = drop_d ? DROP : LINE;
        end
      end
      LINE: begin
        push_req = bus.pix_valid;
        if (accept) begin
          pop = 1'b1;
          k_d = k_q + 16'd1;
          if (k_q == width_q - 16'd1) state_d = LINE_END;
        end
        // A stalled transfer must complete before an abort takes effect.
        if (abort && !(wr && bus.avm_waitrequest)) state_d = IDLE;
      end
      DROP: begin
        push_req   = bus.pix_valid;
        overflow_d = 1'b1;
        if (!fifo_empty) begin
          pop = 1'b1;
          k_d = k_q + 16'd1;
          if (k_q == width_q - 16'd1) state_d = LINE_END;
        end
        if (abort) state_d = IDLE;
      end
      LINE_END: begin
        push_req = bus.pix_valid;
        if (abort) state_d = IDLE;
        else begin
          sel_d   = !sel_q;
          line_d  = line_q + 16'd1;
          state_d = (line_q + 16'd1 == height_q) ? IDLE : CHECK_BUF;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    push = push_req && (!fifo_full || pop);
    if (push_req && fifo_full && !pop) overflow_d = 1'b1;
    wptr_d  = push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop  ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    if (state_q == IDLE) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b0;
      width_q      <= '0;
      height_q     <= '0;
      base0_q      <= '0;
      base1_q      <= '0;
      sel_q        <= 1'b0;
      drop_q       <= 1'b0;
      overflow_q   <= 1'b0;
      line_q       <= '0;
      k_q          <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start_capture;
      width_q      <= width_d;
      height_q     <= height_d;
      base0_q      <= base0_d;
      base1_q      <= base1_d;
      sel_q        <= sel_d;
      drop_q       <= drop_d;
      overflow_q   <= overflow_d;
      line_q       <= line_d;
      k_q          <= k_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      count_q      <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.pix_data;
  end
endmodule

// File: tb/tb_capture_line_scheduler.sv
// Directed bench for capture_line_scheduler: bus writes are checked against a scoreboard
// of expected address/data pairs queued as pixel words are driven.
module tb_capture_line_scheduler;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start_capture = 1'b0;
  logic [15:0] capture_width = 16'd4, capture_height = 16'd2;
  logic [31:0] buff0 = 32'h1000, buff1 = 32'h2000;
  logic        buff0_busy = 1'b0, buff1_busy = 1'b0;
  logic        buff0full, buff1full, frame_done, overflow, busy;

  capture_line_scheduler_if bus ();

  capture_line_scheduler #(.FIFO_DEPTH(8)) dut (
    .clk(clk), .reset_n(reset_n), .start_capture(start_capture),
    .capture_width(capture_width), .capture_height(capture_height),
    .buff0(buff0), .buff1(buff1), .buff0_busy(buff0_busy), .buff1_busy(buff1_busy),
    .bus(bus), .buff0full(buff0full), .buff1full(buff1full),
    .frame_done(frame_done), .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  logic [63:0] exp_q [$];
  int cnt0 = 0, cnt1 = 0, cntfd = 0, hold1004 = 0;
  int s0, s1, sfd, sh;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_addr, prev_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bus monitor: scoreboard compare on accepted writes, hold check while stalled.
  always @(negedge clk) begin
    if (!reset_n) prev_stall = 1'b0;
    else begin
      if (prev_stall) begin
        chk("hold_write", 32'(bus.avm_write), 32'd1);
        chk("hold_addr", bus.avm_address, prev_addr);
        chk("hold_data", bus.avm_writedata, prev_data);
      end
      if (bus.avm_write && !bus.avm_waitrequest) begin
        n_vec++;
        assert (exp_q.size() != 0) else begin
          n_err++;
          $error("FAIL unexpected_write: observed addr %0h data %0h, expected no write",
                 bus.avm_address, bus.avm_writedata);
        end
        if (exp_q.size() != 0) begin
          logic [63:0] e;
          e = exp_q.pop_front();
          chk("wr_addr", bus.avm_address, e[63:32]);
          chk("wr_data", bus.avm_writedata, e[31:0]);
        end
      end
      if (bus.avm_write && bus.avm_address == 32'h1004) hold1004++;
      if (buff0full)  cnt0++;
      if (buff1full)  cnt1++;
      if (frame_done) cntfd++;
      prev_stall = bus.avm_write && bus.avm_waitrequest;
      prev_addr  = bus.avm_address;
      prev_data  = bus.avm_writedata;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic snap();
    s0 = cnt0; s1 = cnt1; sfd = cntfd; sh = hold1004;
  endtask

  task automatic chk_pulses(input string tag, input int e0, input int e1, input int efd);
    chk({tag, "_buff0full"}, 32'(cnt0 - s0), 32'(e0));
    chk({tag, "_buff1full"}, 32'(cnt1 - s1), 32'(e1));
    chk({tag, "_frame_done"}, 32'(cntfd - sfd), 32'(efd));
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic send(input logic [31:0] d, input logic sof);
    bus.pix_valid = 1'b1; bus.pix_data = d; bus.pix_sof = sof;
    cyc();
    bus.pix_valid = 1'b0; bus.pix_sof = 1'b0;
  endtask

  task automatic send_words(input logic [31:0] d0, input int n);
    for (int i = 0; i < n; i++) send(d0 + 32'(i), i == 0);
  endtask

  task automatic push_line(input logic [31:0] base, input logic [31:0] d0, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({base + 32'(4 * i), d0 + 32'(i)});
  endtask

  task automatic arm();
    start_capture = 1'b0; cyc();
    start_capture = 1'b1; cyc();
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 200 && busy; i++) cyc();
    chk(tag, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    bus.pix_valid = 1'b0; bus.pix_sof = 1'b0; bus.pix_data = '0; bus.avm_waitrequest = 1'b0;
    repeat (3) cyc();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_write", 32'(bus.avm_write), 32'd0);
    chk("rst_addr", bus.avm_address, 32'd0);
    chk("rst_wdata", bus.avm_writedata, 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_full", 32'({buff0full, buff1full}), 32'd0);
    reset_n = 1'b1; cyc();

    // Basic two-line frame.
    snap(); arm();
    chk("t1_busy", 32'(busy), 32'd1);
    push_line(32'h1000, 32'hA000_0000, 4);
    push_line(32'h2000, 32'hA000_0004, 4);
    send_words(32'hA000_0000, 8);
    wait_idle("t1_idle");
    chk_pulses("t1", 1, 1, 1);
    chk("t1_overflow", 32'(overflow), 32'd0);

    // Waitrequest stall on the second word; base changed after arming must be ignored.
    snap(); arm();
    buff0 = 32'hDEAD_0000;
    push_line(32'h1000, 32'hB000_0000, 4);
    push_line(32'h2000, 32'hB000_0004, 4);
    fork
      send_words(32'hB000_0000, 8);
      begin
        logic found;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
          @(posedge clk); #1;
          if (bus.avm_write && bus.avm_address == 32'h1004) begin
            found = 1'b1;
            bus.avm_waitrequest = 1'b1;
            repeat (3) @(posedge clk);
            #1 bus.avm_waitrequest = 1'b0;
          end
        end
        chk("t2_stall_seen", 32'(found), 32'd1);
      end
    join
    buff0 = 32'h1000;
    wait_idle("t2_idle");
    chk("t2_hold_cycles", 32'(hold1004 - sh), 32'd4);
    chk_pulses("t2", 1, 1, 1);
    chk("t2_overflow", 32'(overflow), 32'd0);

    // Second buffer busy: line 2 dropped.
    buff1_busy = 1'b1;
    snap(); arm();
    push_line(32'h1000, 32'hC000_0000, 4);
    send_words(32'hC000_0000, 8);
    wait_idle("t3_idle");
    chk_pulses("t3", 1, 0, 1);
    chk("t3_overflow", 32'(overflow), 32'd1);
    buff1_busy = 1'b0;

    // FIFO overflow while the bus is stalled.
    bus.avm_waitrequest = 1'b1;
    snap(); arm();
    chk("t4_overflow_cleared", 32'(overflow), 32'd0);
    push_line(32'h1000, 32'hD000_0000, 4);
    push_line(32'h2000, 32'hD000_0004, 4);
    send_words(32'hD000_0000, 9);
    cyc();
    chk("t4_overflow", 32'(overflow), 32'd1);
    bus.avm_waitrequest = 1'b0;
    wait_idle("t4_idle");
    chk_pulses("t4", 1, 1, 1);
    chk("t4_overflow_sticky", 32'(overflow), 32'd1);

    // Zero width: start edge refused; then pre-SOF words ignored.
    capture_width = 16'd0;
    snap(); arm();
    chk("t5_busy_w0", 32'(busy), 32'd0);
    for (int i = 0; i < 3; i++) send(32'hE000_0000 + 32'(i), 1'b0);
    chk("t5_busy_w0_after", 32'(busy), 32'd0);
    chk("t5_overflow_kept", 32'(overflow), 32'd1);
    capture_width = 16'd4;
    arm();
    for (int i = 0; i < 3; i++) send(32'hF000_0000 + 32'(i), 1'b0);
    chk("t5_busy_wait_sof", 32'(busy), 32'd1);
    push_line(32'h1000, 32'hF000_0010, 4);
    push_line(32'h2000, 32'hF000_0014, 4);
    send_words(32'hF000_0010, 8);
    wait_idle("t5_idle");
    chk_pulses("t5", 1, 1, 1);
    chk("t5_overflow", 32'(overflow), 32'd0);

    // Abort after two words, then restart from buff0.
    snap(); arm();
    push_line(32'h1000, 32'h7000_0000, 2);
    send_words(32'h7000_0000, 2);
    repeat (6) cyc();
    start_capture = 1'b0;
    cyc(); cyc();
    chk("t6_abort_idle", 32'(busy), 32'd0);
    chk_pulses("t6_abort", 0, 0, 0);
    snap(); arm();
    push_line(32'h1000, 32'h8000_0000, 4);
    push_line(32'h2000, 32'h8000_0004, 4);
    send_words(32'h8000_0000, 8);
    wait_idle("t6_idle");
    chk_pulses("t6", 1, 1, 1);
    start_capture = 1'b0;
    repeat (3) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
